// File: rtl/polar_node_sched.sv
// Command-driven sequencer for polar SC kernels (f, g, hard decision r).
// One command streams up to MAX_LEN LLR pairs through a shared datapath with a single output register.
module polar_node_sched #(
    parameter int QTF_SIZE = 8,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [LEN_W-1:0]    cmd_len_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [QTF_SIZE-1:0] in_a_i,
    input  logic [QTF_SIZE-1:0] in_b_i,
    input  logic                in_u_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [QTF_SIZE-1:0] out_data_o,
    output logic                out_last_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] OP_F = 2'd0;
    localparam logic [1:0] OP_G = 2'd1;
    localparam logic [1:0] OP_R = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;
    localparam logic [QTF_SIZE-1:0] MOST_NEG = {1'b1, {(QTF_SIZE-1){1'b0}}};
    localparam logic signed [QTF_SIZE:0] G_HI = (QTF_SIZE+1)'((1 << (QTF_SIZE-1)) - 1);
    localparam logic signed [QTF_SIZE:0] G_LO = -G_HI;

    state_t                state_reg, state_next;
    logic [1:0]            op_reg;
    logic [LEN_W-1:0]      len_reg;
    logic [LEN_W-1:0]      in_cnt_reg;
    logic [QTF_SIZE-1:0]   out_data_reg;
    logic                  out_valid_reg;
    logic                  out_last_reg;
    logic                  err_reg;

    logic                  cmd_fire, in_fire, out_fire;
    logic [LEN_W-1:0]      len_clamped;
    logic [QTF_SIZE-1:0]   a_c, b_c, abs_a, abs_b, mag, f_res, g_res, r_res, result;
    logic signed [QTF_SIZE:0] a_x, b_x, g_sum;

    assign cmd_ready_o = (state_reg == S_IDLE) && !flush_i;
    assign in_ready_o  = (state_reg == S_RUN) && (in_cnt_reg < len_reg)
                         && (!out_valid_reg || out_ready_i) && !flush_i;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = (state_reg == S_RUN) && out_valid_reg && out_ready_i;
    assign len_clamped = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;

    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign out_last_o  = out_last_reg;
    assign busy_o      = (state_reg != S_IDLE);
    assign done_o      = (state_reg == S_DONE);
    assign err_o       = err_reg;

    // Shared f/g/r datapath; the most negative code is folded to keep magnitudes symmetric.
    always_comb begin
        a_c    = (in_a_i == MOST_NEG) ? MOST_NEG + 1'b1 : in_a_i;
        b_c    = (in_b_i == MOST_NEG) ? MOST_NEG + 1'b1 : in_b_i;
        abs_a  = a_c[QTF_SIZE-1] ? -a_c : a_c;
        abs_b  = b_c[QTF_SIZE-1] ? -b_c : b_c;
        mag    = (abs_a < abs_b) ? abs_a : abs_b;
        f_res  = (a_c[QTF_SIZE-1] ^ b_c[QTF_SIZE-1]) ? -mag : mag;
        a_x    = {a_c[QTF_SIZE-1], a_c};
        b_x    = {b_c[QTF_SIZE-1], b_c};
        g_sum  = in_u_i ? (a_x - b_x) : (a_x + b_x);
        if (g_sum > G_HI)
            g_res = G_HI[QTF_SIZE-1:0];
        else if (g_sum < G_LO)
            g_res = G_LO[QTF_SIZE-1:0];
        else
            g_res = g_sum[QTF_SIZE-1:0];
        r_res  = in_u_i ? '0 : {{(QTF_SIZE-1){1'b0}}, a_c[QTF_SIZE-1]};
        result = '0;
        case (op_reg)
            OP_F:    result = f_res;
            OP_G:    result = g_res;
            OP_R:    result = r_res;
            default: result = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (cmd_fire && cmd_op_i != OP_RSV)
                            state_next = (len_clamped == '0) ? S_DONE : S_RUN;
                S_RUN:  if (out_fire && out_last_reg)
                            state_next = S_DONE;
                S_DONE: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= S_IDLE;
            op_reg        <= OP_F;
            len_reg       <= '0;
            in_cnt_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= cmd_fire && (cmd_op_i == OP_RSV);
            if (cmd_fire) begin
                op_reg     <= cmd_op_i;
                len_reg    <= len_clamped;
                in_cnt_reg <= '0;
            end
            // A capture in the same cycle as an output handshake overwrites the register, giving 1 beat/cycle.
            if (flush_i) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end else if (in_fire) begin
                out_data_reg  <= result;
                out_valid_reg <= 1'b1;
                out_last_reg  <= (in_cnt_reg == len_reg - LEN_W'(1));
                in_cnt_reg    <= in_cnt_reg + LEN_W'(1);
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_polar_node_sched.sv
// Directed bench for polar_node_sched: f/g/r vectors, backpressure, edge commands, flush and reset aborts.
module tb_polar_node_sched;
    logic       clk_i, rst_ni, flush_i;
    logic       cmd_valid_i, cmd_ready_o;
    logic [1:0] cmd_op_i;
    logic [4:0] cmd_len_i;
    logic       in_valid_i, in_ready_o, in_u_i;
    logic [7:0] in_a_i, in_b_i;
    logic       out_valid_o, out_ready_i, out_last_o;
    logic [7:0] out_data_o;
    logic       busy_o, done_o, err_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] va[32];
    logic [7:0] vb[32];
    logic       vu[32];
    logic [7:0] ve[32];

    polar_node_sched dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_len_i(cmd_len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_u_i(in_u_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic u, input logic [7:0] e);
        va[i] = a; vb[i] = b; vu[i] = u; ve[i] = e;
    endtask

    // Issues one command, streams nin pairs, checks nexp results and done timing.
    // abort_cyc>0 flushes (or resets) in that cycle after the accept instead of completing.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [4:0] len,
                           input int nin, input int nexp, input int stall_len,
                           input int exp_done_cyc, input int abort_cyc, input bit abort_rst);
        int ii = 0;
        int oi = 0;
        int cyc = 0;
        int stall_left = 0;
        bit stalled_once = 0;
        bit seen_done = 0;
        logic [7:0] hold = '0;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_len_i = len;
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1;
        check({tag, " cmd_ready"}, cmd_ready_o, 1);
        while (!seen_done && cyc < 100) begin
            @(posedge clk_i); #1;
            cyc++;
            cmd_valid_i = 1'b0;
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                in_valid_i = 1'b0; out_ready_i = 1'b1;
                if (!abort_rst) begin
                    flush_i = 1'b1;
                    #1;
                    check({tag, " in_ready in flush"}, in_ready_o, 0);
                    @(posedge clk_i); #1;
                    flush_i = 1'b0;
                    #1;
                    check({tag, " valid after flush"}, out_valid_o, 0);
                    check({tag, " busy after flush"}, busy_o, 0);
                    check({tag, " idle after flush"}, cmd_ready_o, 1);
                    check({tag, " no done"}, done_o, 0);
                end else begin
                    rst_ni = 1'b0;
                    #1;
                    check({tag, " rst valid"}, out_valid_o, 0);
                    check({tag, " rst data"}, out_data_o, 0);
                    check({tag, " rst last"}, out_last_o, 0);
                    check({tag, " rst busy"}, busy_o, 0);
                    check({tag, " rst in_ready"}, in_ready_o, 0);
                    check({tag, " rst done"}, done_o, 0);
                    @(posedge clk_i); #1;
                    rst_ni = 1'b1;
                end
                return;
            end
            in_valid_i = (ii < nin);
            in_a_i = (ii < nin) ? va[ii] : 8'h00;
            in_b_i = (ii < nin) ? vb[ii] : 8'h00;
            in_u_i = (ii < nin) ? vu[ii] : 1'b0;
            if (!stalled_once && stall_len > 0 && out_valid_o) begin
                stall_left = stall_len;
                stalled_once = 1;
                hold = out_data_o;
            end
            out_ready_i = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check({tag, " stall in_ready"}, in_ready_o, 0);
                check({tag, " stall data"}, out_data_o, hold);
                stall_left--;
            end
            if (out_valid_o && out_ready_i) begin
                check($sformatf("%s data[%0d]", tag, oi), out_data_o, ve[oi]);
                check($sformatf("%s last[%0d]", tag, oi), out_last_o, (oi == nexp - 1));
                oi++;
            end
            if (in_valid_i && in_ready_o) ii++;
            if (done_o) begin
                seen_done = 1;
                check({tag, " done cycle"}, cyc, exp_done_cyc);
                check({tag, " out count"}, oi, nexp);
                check({tag, " in count"}, ii, nexp);
                check({tag, " no err"}, err_o, 0);
            end
        end
        if (!seen_done) check({tag, " done timeout"}, 0, 1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        #1;
        check({tag, " done one cycle"}, done_o, 0);
        check({tag, " idle after done"}, busy_o, 0);
        $display("cmd %s op=%0d len=%0d: %0d results in %0d cycles", tag, op, len, oi, cyc);
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_len_i = '0;
        in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; in_u_i = 1'b0; out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset valid", out_valid_o, 0);
        check("reset data", out_data_o, 0);
        check("reset done", done_o, 0);
        check("reset err", err_o, 0);
        check("reset busy", busy_o, 0);
        check("reset in_ready", in_ready_o, 0);
        rst_ni = 1'b1;

        set_vec(0, 8'hFB, 8'h03, 1'b0, 8'hFD);
        set_vec(1, 8'h80, 8'h80, 1'b0, 8'h7F);
        run_cmd("F2", 2'd0, 5'd2, 2, 2, 0, 4, 0, 0);

        set_vec(0, 8'd100, 8'd100, 1'b0, 8'h7F);
        set_vec(1, 8'h9C, 8'd100, 1'b1, 8'h81);
        set_vec(2, 8'd20, 8'hF9, 1'b1, 8'h1B);
        run_cmd("G3", 2'd1, 5'd3, 3, 3, 0, 5, 0, 0);

        set_vec(0, 8'hFF, 8'h40, 1'b0, 8'h01);
        set_vec(1, 8'hFF, 8'h40, 1'b1, 8'h00);
        run_cmd("R2", 2'd2, 5'd2, 2, 2, 0, 4, 0, 0);

        set_vec(0, 8'd10, 8'hEC, 1'b0, 8'hF6);
        set_vec(1, 8'hF9, 8'hF7, 1'b0, 8'h07);
        set_vec(2, 8'd50, 8'd60, 1'b0, 8'h32);
        set_vec(3, 8'h80, 8'd5, 1'b0, 8'hFB);
        run_cmd("F4bp", 2'd0, 5'd4, 4, 4, 3, 9, 0, 0);

        run_cmd("len0", 2'd0, 5'd0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 18; i++) set_vec(i, 8'(i), 8'd1, 1'b0, 8'(i + 1));
        run_cmd("Gclamp", 2'd1, 5'd20, 18, 16, 0, 18, 0, 0);

        // Reserved op: error pulse for one cycle, never busy, never done.
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_op_i = 2'd3; cmd_len_i = 5'd4;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        check("op3 err pulse", err_o, 1);
        check("op3 busy", busy_o, 0);
        @(posedge clk_i); #1;
        check("op3 err one cycle", err_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            check("op3 no done", done_o, 0);
        end
        $display("cmd op3: err pulse observed=%0d", 1);

        for (int i = 0; i < 8; i++) set_vec(i, 8'(i + 1), 8'(2 * i + 2), 1'b0, 8'(i + 1));
        run_cmd("flush8", 2'd0, 5'd8, 8, 8, 0, 0, 3, 0);
        run_cmd("after_flush", 2'd0, 5'd2, 2, 2, 0, 4, 0, 0);
        run_cmd("rst8", 2'd0, 5'd8, 8, 8, 0, 0, 3, 1);
        run_cmd("after_rst", 2'd0, 5'd3, 3, 3, 0, 5, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/polar_node_sched.md
Name: polar_node_sched

Overview:
- Command-driven sequencer for the polar successive-cancellation kernels (f, g, hard decision r) on QTF_SIZE-bit signed LLRs.
- Accepts one command (op, length), then streams LLR pairs through a single shared f/g/r datapath at one element per cycle, with one registered output stage.
- Sits beside the integer ALU in the execute stage, so that whole polar node stages run without issuing one instruction per element.

Parameters:
- QTF_SIZE, 8, LLR width in bits (two's complement).
- MAX_LEN, 16, maximum elements per command.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort of the current command.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_op_i  in  2  0=F, 1=G, 2=R, 3=reserved.
- cmd_len_i  in  LEN_W  number of elements.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  operand pair accepted.
- in_a_i  in  QTF_SIZE  LLR a.
- in_b_i  in  QTF_SIZE  LLR b.
- in_u_i  in  1  G: partial-sum bit; R: frozen flag; ignored for F.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed.
- out_data_o  out  QTF_SIZE  result.
- out_last_o  out  1  marks the final result of the command.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse after the last result handshake.
- err_o  out  1  one-cycle pulse when a reserved op is accepted.

Behaviour:
- Reset (asynchronous, rst_ni low): state=IDLE; all outputs 0 (out_data_o=0, out_valid_o=0, done_o=0, err_o=0); counters cleared. Reset mid-command discards all state.
- States:
  - IDLE: cmd_ready_o = !flush_i. On accept, latch op and len, clear in_cnt/out_cnt, go to RUN.
    - len==0: go to DONE instead of RUN.
    - len>MAX_LEN: clamp to MAX_LEN.
    - op==3: pulse err_o the next cycle, go to IDLE, no done_o.
  - RUN: in_ready_o = (in_cnt < len) & (!out_valid_o | out_ready_i) & !flush_i.
    - On an input handshake: register the result into out_data_o and set out_valid_o the next cycle (latency 1 cycle). in_cnt++. out_last_o = (in_cnt == len-1) at capture.
    - On an output handshake: out_cnt++. If the handshaken beat has out_last_o set, go to DONE.
    - Input and output handshakes in the same cycle are legal; the output register is overwritten with no bubble, giving 1 element/cycle sustained.
  - DONE: done_o=1 for exactly one cycle, then go to IDLE. The next command can be accepted in the following cycle.
- Outside RUN: in_ready_o=0. Outputs hold stable while out_valid_o & !out_ready_i.
- flush_i (any state): next cycle state=IDLE and out_valid_o=0. No done_o. Pending data is dropped. flush_i wins over a simultaneous cmd_valid_i.
- Arithmetic (signed, QTF_SIZE=8 values shown):
  - Input clamp: -128 (0x80) on a or b is treated as -127 before any op.
  - F: sign = sign(a) XOR sign(b); mag = min(|a|,|b|); result = sign ? -mag : mag. A zero operand counts as positive.
  - G: computed at QTF_SIZE+1 bits. s = u ? (a - b) : (a + b). Saturate: s>127 gives 0x7F; s<-127 gives 0x81; otherwise s[7:0].
  - R: frozen (u=1) gives 0x00; else a<0 gives 0x01, else 0x00. b is ignored.
- Results are zero-extended into any upper bits the consumer uses; the block outputs only QTF_SIZE bits.

Test Plan:
- F, len=2: (a=-5,b=3), (a=0x80,b=0x80) -> out 0xFD, then 0x7F with out_last_o=1; done_o pulses 1 cycle after the second output handshake.
- G, len=3: (100,100,u=0), (-100,100,u=1), (20,-7,u=1) -> 0x7F, 0x81, 0x1B.
- R, len=2: (a=-1,u=0), (a=-1,u=1) -> 0x01, 0x00.
- Backpressure, F len=4, in_valid_i held high: drop out_ready_i for 3 cycles after the first result -> in_ready_o=0 and out_data_o stable during the stall; 4 results in order with no loss or duplication; throughput 1/cycle once ready returns.
- Edge commands: len=0 -> done_o 1 cycle after accept, no out_valid_o. op=3 -> err_o pulse, no done_o. len=MAX_LEN+... clamps to MAX_LEN outputs.
- Flush at element 2 of len=8 -> IDLE next cycle, out_valid_o=0, no done_o; a new command on the following cycle completes normally. Repeat the scenario with rst_ni asserted mid-run -> all outputs 0 immediately.
